// File: rtl/subcode_frame_buffer.sv
// Frames P..W subcode symbols on SCOR, stores each 96-symbol frame in a ping-pong
// buffer for the host and checks the Q-channel CRC of every frame.
module subcode_frame_buffer #(
  parameter int SYNC_SKIP = 2,
  parameter int FRAME_LEN = 96
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sub_stb_i,
  input  logic [7:0] sub_data_i,
  input  logic       scor_i,
  input  logic [6:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  input  logic       frame_ack_i,
  output logic       frame_rdy_o,
  output logic       q_crc_ok_o,
  output logic       overrun_o,
  output logic       sync_lost_o
);

  localparam int AW       = $clog2(2 * FRAME_LEN);
  localparam int SW       = (SYNC_SKIP > 1) ? $clog2(SYNC_SKIP) : 1;
  localparam int CRC_BITS = FRAME_LEN - 16;

  typedef enum logic [1:0] {HUNT, SKIP, DATA, COMMIT} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   skip_q, skip_d;
  logic [6:0]      idx_q, idx_d;
  logic [15:0]     crc_q, crc_d;
  logic [15:0]     rx_crc_q, rx_crc_d;
  logic            wr_bank_q, wr_bank_d;
  logic            frame_rdy_q, frame_rdy_d;
  logic            q_crc_ok_q, q_crc_ok_d;
  logic            overrun_q, overrun_d;
  logic            sync_lost_q, sync_lost_d;
  logic            scor_meta_q, scor_sync_q, scor_prev_q;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            scor_edge;
  logic            mem_we;
  logic [15:0]     crc_step;
  logic            rd_in_range;
  logic [AW-1:0]   wr_addr, rd_addr_full;

  logic [7:0] mem [2*FRAME_LEN];

  assign scor_edge = scor_sync_q & ~scor_prev_q;
  assign crc_step  = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ sub_data_i[6]) ? 16'h1021 : 16'h0000);

  // Bank 1 occupies the upper FRAME_LEN entries; the read bank is always the other one.
  assign wr_addr      = AW'(idx_q) + (wr_bank_q ? AW'(FRAME_LEN) : {AW{1'b0}});
  assign rd_in_range  = rd_addr_i < 7'(FRAME_LEN);
  assign rd_addr_full = (rd_in_range ? AW'(rd_addr_i) : {AW{1'b0}}) +
                        (wr_bank_q ? {AW{1'b0}} : AW'(FRAME_LEN));
  assign rd_data_d    = rd_in_range ? mem[rd_addr_full] : 8'h00;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_addr] <= sub_data_i;
  end

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    idx_d       = idx_q;
    crc_d       = crc_q;
    rx_crc_d    = rx_crc_q;
    wr_bank_d   = wr_bank_q;
    frame_rdy_d = frame_rdy_q;
    q_crc_ok_d  = q_crc_ok_q;
    overrun_d   = overrun_q;
    sync_lost_d = sync_lost_q;
    mem_we      = 1'b0;
    if (frame_ack_i) begin
      frame_rdy_d = 1'b0;
      overrun_d   = 1'b0;
      sync_lost_d = 1'b0;
    end
    unique case (state_q)
      HUNT: begin
        if (scor_edge) begin
          state_d = SKIP;
          skip_d  = '0;
        end
      end
      SKIP: begin
        // A sync edge always takes priority over a coincident strobe.
        if (scor_edge) begin
          sync_lost_d = 1'b1;
          skip_d      = '0;
        end else if (sub_stb_i) begin
          if (skip_q == SW'(SYNC_SKIP - 1)) begin
            state_d  = DATA;
            idx_d    = '0;
            crc_d    = '0;
            rx_crc_d = '0;
          end else begin
            skip_d = skip_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (scor_edge) begin
          sync_lost_d = 1'b1;
          state_d     = SKIP;
          skip_d      = '0;
        end else if (sub_stb_i) begin
          mem_we = 1'b1;
          idx_d  = idx_q + 7'd1;
          if (idx_q < 7'(CRC_BITS)) crc_d = crc_step;
          else                      rx_crc_d = {rx_crc_q[14:0], sub_data_i[6]};
          if (idx_q == 7'(FRAME_LEN - 1)) state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (!frame_rdy_q || frame_ack_i) begin
          wr_bank_d   = ~wr_bank_q;
          frame_rdy_d = 1'b1;
          q_crc_ok_d  = (crc_q == ~rx_crc_q);
        end else begin
          overrun_d = 1'b1;
        end
        skip_d  = '0;
        state_d = scor_edge ? SKIP : HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HUNT;
      skip_q      <= '0;
      idx_q       <= '0;
      crc_q       <= '0;
      rx_crc_q    <= '0;
      wr_bank_q   <= 1'b0;
      frame_rdy_q <= 1'b0;
      q_crc_ok_q  <= 1'b0;
      overrun_q   <= 1'b0;
      sync_lost_q <= 1'b0;
      scor_meta_q <= 1'b0;
      scor_sync_q <= 1'b0;
      scor_prev_q <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      idx_q       <= idx_d;
      crc_q       <= crc_d;
      rx_crc_q    <= rx_crc_d;
      wr_bank_q   <= wr_bank_d;
      frame_rdy_q <= frame_rdy_d;
      q_crc_ok_q  <= q_crc_ok_d;
      overrun_q   <= overrun_d;
      sync_lost_q <= sync_lost_d;
      scor_meta_q <= scor_i;
      scor_sync_q <= scor_meta_q;
      scor_prev_q <= scor_sync_q;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign frame_rdy_o = frame_rdy_q;
  assign q_crc_ok_o  = q_crc_ok_q;
  assign overrun_o   = overrun_q;
  assign sync_lost_o = sync_lost_q;

endmodule

// File: tb/tb_subcode_frame_buffer.sv
// Randomized bench for subcode_frame_buffer against a frame-level reference model.
module tb_subcode_frame_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sub_stb;
  logic [7:0] sub_data;
  logic       scor;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_ack;
  logic       frame_rdy;
  logic       q_crc_ok;
  logic       overrun;
  logic       sync_lost;

  always #5 clk = ~clk;

  subcode_frame_buffer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sub_stb_i   (sub_stb),
    .sub_data_i  (sub_data),
    .scor_i      (scor),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .frame_ack_i (frame_ack),
    .frame_rdy_o (frame_rdy),
    .q_crc_ok_o  (q_crc_ok),
    .overrun_o   (overrun),
    .sync_lost_o (sync_lost)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx [96];
  logic [7:0] ref_frame [96];
  logic [7:0] qb [12];
  bit ref_rdy, ref_ovr, ref_sl, ref_qok;

  // Bytewise CRC-16-CCITT over the first ten Q bytes in qb.
  function automatic logic [15:0] qcrc();
    logic [15:0] c = 16'h0000;
    for (int b = 0; b < 10; b++) begin
      c = c ^ {qb[b], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic bit tx_crc_ok();
    for (int i = 0; i < 96; i++) qb[i/8][7-(i%8)] = tx[i][6];
    return qcrc() == ~{qb[10], qb[11]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_scor();
    scor = 1'b1;
    tick(2);
    scor = 1'b0;
    tick(3);
  endtask

  task automatic send_sym(input logic [7:0] d, input int gap);
    sub_stb  = 1'b1;
    sub_data = d;
    tick(1);
    sub_stb  = 1'b0;
    sub_data = 8'($urandom);
    tick(gap);
  endtask

  // Ends on the negedge right after the last strobe (the cycle the commit happens).
  task automatic send_frame();
    send_scor();
    send_sym(8'($urandom), int'($urandom_range(0, 2)));
    send_sym(8'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 95; i++) send_sym(tx[i], int'($urandom_range(0, 2)));
    send_sym(tx[95], 0);
    $display("frame sent: first=%02h last=%02h", tx[0], tx[95]);
  endtask

  task automatic model_commit();
    if (!ref_rdy) begin
      ref_frame = tx;
      ref_rdy   = 1'b1;
      ref_qok   = tx_crc_ok();
    end else begin
      ref_ovr = 1'b1;
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    ref_rdy = 1'b0;
    ref_ovr = 1'b0;
    ref_sl  = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    rd_addr = a;
    tick(1);
    d = rd_data;
  endtask

  task automatic rand_tx();
    for (int i = 0; i < 96; i++) tx[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_checks++; if (frame_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", frame_rdy); end
    n_checks++; if (q_crc_ok !== 1'b0) begin n_fail++; $display("FAIL reset_qok: got %b want 0", q_crc_ok); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    n_checks++; if (sync_lost !== 1'b0) begin n_fail++; $display("FAIL reset_sl: got %b want 0", sync_lost); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd: got %h want 00", rd_data); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    logic [7:0] d;
    for (int i = 0; i < 96; i++) tx[i] = 8'(i);
    send_frame();
    n_checks++; if (frame_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_early: got %b want 0", frame_rdy); end
    tick(1);
    model_commit();
    n_checks++; if (frame_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy: got %b want 1", frame_rdy); end
    n_checks++; if (q_crc_ok !== ref_qok) begin n_fail++; $display("FAIL basic_qok: got %b want %b", q_crc_ok, ref_qok); end
    rd(7'd5, d);
    n_checks++; if (d !== 8'h05) begin n_fail++; $display("FAIL basic_rd5: got %h want 05", d); end
    rd(7'd100, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL basic_rd100: got %h want 00", d); end
    rd(7'd95, d);
    n_checks++; if (d !== 8'h5f) begin n_fail++; $display("FAIL basic_rd95: got %h want 5f", d); end
    rd(7'd127, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL basic_rd127: got %h want 00", d); end
    do_ack();
    n_checks++; if (frame_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_ack: got %b want 0", frame_rdy); end
  endtask

  task automatic test_qcrc();
    logic [15:0] c;
    int k;
    qb = '{8'h41, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
    c = qcrc();
    qb[10] = ~c[15:8];
    qb[11] = ~c[7:0];
    for (int i = 0; i < 96; i++) begin
      tx[i] = 8'($urandom);
      tx[i][6] = qb[i/8][7-(i%8)];
    end
    send_frame();
    tick(1);
    model_commit();
    n_checks++; if (q_crc_ok !== 1'b1) begin n_fail++; $display("FAIL qcrc_good: got %b want 1", q_crc_ok); end
    do_ack();
    k = int'($urandom_range(0, 95));
    tx[k][6] = ~tx[k][6];
    send_frame();
    tick(1);
    model_commit();
    n_checks++; if (q_crc_ok !== 1'b0) begin n_fail++; $display("FAIL qcrc_bad bit%0d: got %b want 0", k, q_crc_ok); end
    do_ack();
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 0; i < 96; i++) tx[i] = 8'hAA;
    send_frame();
    tick(1);
    model_commit();
    for (int i = 0; i < 96; i++) tx[i] = 8'h55;
    send_frame();
    tick(1);
    model_commit();
    n_checks++; if (overrun !== ref_ovr) begin n_fail++; $display("FAIL ovr_set: got %b want %b", overrun, ref_ovr); end
    n_checks++; if (frame_rdy !== 1'b1) begin n_fail++; $display("FAIL ovr_rdy: got %b want 1", frame_rdy); end
    for (int a = 0; a < 96; a++) begin
      rd(7'(a), d);
      n_checks++; if (d !== ref_frame[a]) begin n_fail++; $display("FAIL ovr_data[%0d]: got %h want %h", a, d, ref_frame[a]); end
    end
    do_ack();
    n_checks++; if (frame_rdy !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack: got rdy=%b ovr=%b want 0 0", frame_rdy, overrun); end
  endtask

  task automatic test_sync_lost();
    logic [7:0] d;
    int a;
    rand_tx();
    send_scor();
    send_sym(8'($urandom), 1);
    send_sym(8'($urandom), 1);
    for (int i = 0; i < 50; i++) send_sym(tx[i], int'($urandom_range(0, 2)));
    send_scor();
    ref_sl = 1'b1;
    n_checks++; if (sync_lost !== 1'b1) begin n_fail++; $display("FAIL sl_set: got %b want 1", sync_lost); end
    n_checks++; if (frame_rdy !== 1'b0) begin n_fail++; $display("FAIL sl_rdy: got %b want 0", frame_rdy); end
    rand_tx();
    send_frame();
    tick(1);
    model_commit();
    n_checks++; if (frame_rdy !== 1'b1) begin n_fail++; $display("FAIL sl_next_rdy: got %b want 1", frame_rdy); end
    n_checks++; if (q_crc_ok !== ref_qok) begin n_fail++; $display("FAIL sl_next_qok: got %b want %b", q_crc_ok, ref_qok); end
    for (int j = 0; j < 4; j++) begin
      a = int'($urandom_range(0, 95));
      rd(7'(a), d);
      n_checks++; if (d !== ref_frame[a]) begin n_fail++; $display("FAIL sl_data[%0d]: got %h want %h", a, d, ref_frame[a]); end
    end
    do_ack();
    n_checks++; if (sync_lost !== 1'b0) begin n_fail++; $display("FAIL sl_ack: got %b want 0", sync_lost); end
  endtask

  task automatic test_ack_in_commit();
    logic [7:0] d;
    int a;
    rand_tx();
    send_frame();
    tick(1);
    model_commit();
    rand_tx();
    send_frame();
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    ref_frame = tx;
    ref_rdy   = 1'b1;
    ref_ovr   = 1'b0;
    ref_sl    = 1'b0;
    ref_qok   = tx_crc_ok();
    n_checks++; if (frame_rdy !== 1'b1) begin n_fail++; $display("FAIL aic_rdy: got %b want 1", frame_rdy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL aic_ovr: got %b want 0", overrun); end
    n_checks++; if (q_crc_ok !== ref_qok) begin n_fail++; $display("FAIL aic_qok: got %b want %b", q_crc_ok, ref_qok); end
    for (int j = 0; j < 6; j++) begin
      a = int'($urandom_range(0, 95));
      rd(7'(a), d);
      n_checks++; if (d !== ref_frame[a]) begin n_fail++; $display("FAIL aic_data[%0d]: got %h want %h", a, d, ref_frame[a]); end
    end
    do_ack();
  endtask

  task automatic test_random();
    logic [7:0] d;
    int a;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1) do_ack();
      rand_tx();
      if ($urandom_range(0, 2) == 0) begin
        tx[3][6] = ~tx[3][6];
      end else begin
        for (int i = 0; i < 96; i++) qb[i/8][7-(i%8)] = tx[i][6];
        {qb[10], qb[11]} = ~qcrc();
        for (int i = 80; i < 96; i++) tx[i][6] = qb[i/8][7-(i%8)];
      end
      send_frame();
      tick(1);
      model_commit();
      n_checks++; if (frame_rdy !== ref_rdy) begin n_fail++; $display("FAIL rnd%0d_rdy: got %b want %b", f, frame_rdy, ref_rdy); end
      n_checks++; if (overrun !== ref_ovr) begin n_fail++; $display("FAIL rnd%0d_ovr: got %b want %b", f, overrun, ref_ovr); end
      n_checks++; if (q_crc_ok !== ref_qok) begin n_fail++; $display("FAIL rnd%0d_qok: got %b want %b", f, q_crc_ok, ref_qok); end
      a = int'($urandom_range(0, 95));
      rd(7'(a), d);
      n_checks++; if (d !== ref_frame[a]) begin n_fail++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", f, a, d, ref_frame[a]); end
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int a;
    rand_tx();
    send_frame();
    tick(1);
    model_commit();
    rand_tx();
    send_scor();
    send_sym(8'($urandom), 0);
    send_sym(8'($urandom), 0);
    for (int i = 0; i < 30; i++) send_sym(tx[i], 1);
    #2 rst = 1'b1;
    #1;
    ref_rdy = 1'b0; ref_ovr = 1'b0; ref_sl = 1'b0; ref_qok = 1'b0;
    n_checks++; if (frame_rdy !== 1'b0 || overrun !== 1'b0 || sync_lost !== 1'b0 || q_crc_ok !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_flags: got rdy=%b ovr=%b sl=%b qok=%b want 0", frame_rdy, overrun, sync_lost, q_crc_ok); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rd: got %h want 00", rd_data); end
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 120; i++) send_sym(8'($urandom), 0);
    tick(2);
    n_checks++; if (frame_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_nocommit: got %b want 0", frame_rdy); end
    rand_tx();
    send_frame();
    tick(1);
    model_commit();
    n_checks++; if (frame_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy: got %b want 1", frame_rdy); end
    for (int j = 0; j < 4; j++) begin
      a = int'($urandom_range(0, 95));
      rd(7'(a), d);
      n_checks++; if (d !== ref_frame[a]) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %h want %h", a, d, ref_frame[a]); end
    end
    do_ack();
  endtask

  initial begin
    rst = 1'b1; sub_stb = 1'b0; sub_data = 8'h00; scor = 1'b0;
    rd_addr = 7'd0; frame_ack = 1'b0;
    ref_rdy = 1'b0; ref_ovr = 1'b0; ref_sl = 1'b0; ref_qok = 1'b0;
    test_reset();
    test_basic();
    test_qcrc();
    test_overrun();
    test_sync_lost();
    test_ack_in_commit();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
